// File: rtl/operand_sequencer.sv
// Captures COUNT operands from data_in, one per debounced operator press on go.
// A press is accepted after HOLD_CYCLES consecutive high samples and committed on its release.
module operand_sequencer #(
  parameter int WIDTH       = 4,
  parameter int COUNT       = 2,
  parameter int HOLD_CYCLES = 3,
  localparam int IDX_W      = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH*COUNT-1:0]   operands,
  output logic [IDX_W-1:0]         index,
  output logic                     wait_led,
  output logic                     capture_pulse,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_HELD    = 2'd2,
    S_FULL    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         counter_q, counter_d;
  logic [WIDTH*COUNT-1:0]   operands_q, operands_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic                     wait_q, wait_d;
  logic                     pulse_q, pulse_d;
  logic                     done_q, done_d;
  logic                     capture;

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    operands_d = operands_q;
    index_d    = index_q;
    wait_d     = wait_q;
    pulse_d    = 1'b0;
    done_d     = done_q;
    capture    = 1'b0;

    if (clear) begin
      // Abort wins over go; a press still held afterwards re-qualifies from scratch.
      state_d    = S_IDLE;
      counter_d  = '0;
      operands_d = '0;
      index_d    = '0;
      wait_d     = 1'b0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            if (HOLD_CYCLES == 1) begin
              capture = 1'b1;
            end else begin
              counter_d = CNT_W'(1);
              state_d   = S_QUALIFY;
            end
          end
        end
        S_QUALIFY: begin
          if (!go) begin
            counter_d = '0;
            state_d   = S_IDLE;
          end else if (counter_q == CNT_W'(HOLD_CYCLES - 1)) begin
            capture = 1'b1;
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!go) begin
            wait_d  = 1'b0;
            pulse_d = 1'b1;
            if (index_q < IDX_W'(COUNT - 1)) begin
              index_d = index_q + IDX_W'(1);
              state_d = S_IDLE;
            end else begin
              done_d  = 1'b1;
              state_d = S_FULL;
            end
          end
        end
        default: begin
          // FULL: go is ignored until clear or reset.
        end
      endcase

      if (capture) begin
        for (int k = 0; k < COUNT; k++) begin
          if (index_q == IDX_W'(k)) begin
            operands_d[k*WIDTH +: WIDTH] = data_in;
          end
        end
        wait_d    = 1'b1;
        counter_d = '0;
        state_d   = S_HELD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      counter_q  <= '0;
      operands_q <= '0;
      index_q    <= '0;
      wait_q     <= 1'b0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      operands_q <= operands_d;
      index_q    <= index_d;
      wait_q     <= wait_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
    end
  end

  assign operands      = operands_q;
  assign index         = index_q;
  assign wait_led      = wait_q;
  assign capture_pulse = pulse_q;
  assign done          = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer (WIDTH=4, COUNT=2, HOLD_CYCLES=3): directed vector table,
// a hand-written glitch sequence, and random presses checked against a run-length model.
module tb_operand_sequencer;

  localparam int WIDTH = 4;
  localparam int COUNT = 2;
  localparam int HOLD  = 3;
  localparam int IDX_W = 1;
  localparam int OW    = WIDTH * COUNT;
  localparam int PW    = OW + IDX_W + 3;

  logic             clk = 1'b0;
  logic             reset, go, clear;
  logic [WIDTH-1:0] data_in;
  logic [OW-1:0]    operands;
  logic [IDX_W-1:0] index;
  logic             wait_led, capture_pulse, done;
  logic [1:0]       state_dbg;

  int tests = 0;
  int fails = 0;

  operand_sequencer #(.WIDTH(WIDTH), .COUNT(COUNT), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .go(go), .clear(clear), .data_in(data_in),
    .operands(operands), .index(index), .wait_led(wait_led),
    .capture_pulse(capture_pulse), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             g;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic [OW-1:0]    e_ops;
    logic [IDX_W-1:0] e_idx;
    logic             e_w;
    logic             e_p;
    logic             e_dn;
  } vec_t;

  vec_t vecs[$];
  logic [PW-1:0] exp_q[$];

  // Reference model: counts consecutive go-high samples, no state encoding.
  logic [WIDTH-1:0] m_ops[COUNT];
  int               m_idx, m_run;
  bit               m_acc, m_pulse, m_done;

  function automatic void add(input logic r, g, c, input logic [WIDTH-1:0] d,
                              input logic [OW-1:0] ops, input logic [IDX_W-1:0] idx,
                              input logic w, p, dn);
    vec_t v;
    v.rst = r; v.g = g; v.clr = c; v.d = d;
    v.e_ops = ops; v.e_idx = idx; v.e_w = w; v.e_p = p; v.e_dn = dn;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, g, c, input logic [WIDTH-1:0] d);
    reset = r; go = g; clear = c; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [OW-1:0] e_ops,
                       input logic [IDX_W-1:0] e_idx, input logic e_w, e_p, e_dn);
    tests++;
    if ({operands, index, wait_led, capture_pulse, done} !== {e_ops, e_idx, e_w, e_p, e_dn}) begin
      fails++;
      $display("FAIL %s: got ops=%h idx=%0d wait=%b pulse=%b done=%b, expected ops=%h idx=%0d wait=%b pulse=%b done=%b",
               name, operands, index, wait_led, capture_pulse, done, e_ops, e_idx, e_w, e_p, e_dn);
    end
  endtask

  task automatic model_step(input bit r, g, c, input logic [WIDTH-1:0] d);
    m_pulse = 1'b0;
    if (r || c) begin
      for (int k = 0; k < COUNT; k++) m_ops[k] = '0;
      m_idx = 0; m_run = 0; m_acc = 1'b0; m_done = 1'b0;
    end else if (m_done) begin
      // sequence complete: presses ignored
    end else if (m_acc) begin
      if (!g) begin
        m_acc   = 1'b0;
        m_pulse = 1'b1;
        if (m_idx == COUNT - 1) m_done = 1'b1;
        else m_idx++;
      end
    end else if (g) begin
      m_run++;
      if (m_run == HOLD) begin
        m_acc        = 1'b1;
        m_ops[m_idx] = d;
        m_run        = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  function automatic logic [PW-1:0] model_pack();
    logic [OW-1:0] ops;
    for (int k = 0; k < COUNT; k++) ops[k*WIDTH +: WIDTH] = m_ops[k];
    return {ops, IDX_W'(m_idx), m_acc, m_pulse, m_done};
  endfunction

  initial begin
    bit               g_cur;
    bit               r, c;
    int               go_left;
    logic [WIDTH-1:0] d;
    logic [PW-1:0]    e;

    reset = 1'b1; go = 1'b0; clear = 1'b0; data_in = '0;

    //   rst go clr  d      ops    idx  w  p  dn
    add(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 4'hA, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 4'hA, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 4'hA, 8'h0A, 0, 1, 0, 0);
    add(0, 0, 0, 4'hA, 8'h0A, 1, 0, 1, 0);
    add(0, 0, 0, 4'hA, 8'h0A, 1, 0, 0, 0);
    // two-cycle press is rejected
    add(0, 1, 0, 4'h3, 8'h0A, 1, 0, 0, 0);
    add(0, 1, 0, 4'h3, 8'h0A, 1, 0, 0, 0);
    add(0, 0, 0, 4'h3, 8'h0A, 1, 0, 0, 0);
    add(0, 0, 0, 4'h3, 8'h0A, 1, 0, 0, 0);
    // second operand; data toggles while held
    add(0, 1, 0, 4'h5, 8'h0A, 1, 0, 0, 0);
    add(0, 1, 0, 4'h5, 8'h0A, 1, 0, 0, 0);
    add(0, 1, 0, 4'h5, 8'h5A, 1, 1, 0, 0);
    add(0, 1, 0, 4'hF, 8'h5A, 1, 1, 0, 0);
    add(0, 1, 0, 4'h0, 8'h5A, 1, 1, 0, 0);
    add(0, 0, 0, 4'hC, 8'h5A, 1, 0, 1, 1);
    add(0, 0, 0, 4'hC, 8'h5A, 1, 0, 0, 1);
    // five-cycle press in FULL has no effect
    for (int i = 0; i < 5; i++) add(0, 1, 0, 4'h7, 8'h5A, 1, 0, 0, 1);
    add(0, 0, 0, 4'h7, 8'h5A, 1, 0, 0, 1);
    // clear, then clear during HELD with go still high
    add(0, 0, 1, 4'h0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 4'h9, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 4'h9, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 4'h9, 8'h09, 0, 1, 0, 0);
    add(0, 1, 1, 4'h9, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 4'h6, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 4'h6, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 4'h6, 8'h06, 0, 1, 0, 0);
    add(0, 0, 0, 4'h6, 8'h06, 1, 0, 1, 0);
    // reset in HELD discards the press without a pulse
    add(0, 1, 0, 4'h2, 8'h06, 1, 0, 0, 0);
    add(0, 1, 0, 4'h2, 8'h06, 1, 0, 0, 0);
    add(0, 1, 0, 4'h2, 8'h26, 1, 1, 0, 0);
    add(1, 0, 0, 4'h2, 8'h00, 0, 0, 0, 0);
    add(0, 0, 0, 4'h2, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].g, vecs[i].clr, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].e_ops, vecs[i].e_idx, vecs[i].e_w, vecs[i].e_p, vecs[i].e_dn);
    end

    // Glitchy press pattern never accepts; an unbroken 3-cycle press then does.
    step(0, 1, 0, 4'hB); check("glitch_a", 8'h00, 0, 0, 0, 0);
    step(0, 0, 0, 4'hB); check("glitch_b", 8'h00, 0, 0, 0, 0);
    step(0, 1, 0, 4'hB); check("glitch_c", 8'h00, 0, 0, 0, 0);
    step(0, 1, 0, 4'hB); check("glitch_d", 8'h00, 0, 0, 0, 0);
    step(0, 0, 0, 4'hB); check("glitch_e", 8'h00, 0, 0, 0, 0);
    step(0, 1, 0, 4'hE); check("press_1", 8'h00, 0, 0, 0, 0);
    step(0, 1, 0, 4'hE); check("press_2", 8'h00, 0, 0, 0, 0);
    step(0, 1, 0, 4'hE); check("press_3", 8'h0E, 0, 1, 0, 0);
    step(0, 0, 0, 4'h1); check("release", 8'h0E, 1, 0, 1, 0);

    // Random presses against the model.
    model_step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    g_cur   = 1'b0;
    go_left = 0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 24) == 0);
      if (go_left == 0) begin
        g_cur   = ~g_cur;
        go_left = $urandom_range(1, 6);
      end
      go_left--;
      d = WIDTH'($urandom_range(0, 15));
      model_step(r, g_cur, c, d);
      exp_q.push_back(model_pack());
      step(r, g_cur, c, d);
      e = exp_q.pop_front();
      check($sformatf("rand%0d", i), e[PW-1:IDX_W+3], e[IDX_W+2:3], e[2], e[1], e[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
